// File: rtl/multiplier_control.sv
// Sequencing FSM for the shift-add signed multiplier: clears/loads operands,
// then runs N add-then-shift iterations, subtracting on the final one.
module multiplier_control #(
    parameter int N = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear_a_load_b,
    input  logic i_m,
    output logic o_clr_ax,
    output logic o_ld_b,
    output logic o_ld_ax,
    output logic o_fn,
    output logic o_shift_en,
    output logic o_busy,
    output logic o_done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        HALT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The counter saturates at N-1; HALT holds it until the next START clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == START) begin
            r_cnt <= '0;
        end else if (r_state == SHIFT && !w_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        o_clr_ax   = 1'b0;
        o_ld_b     = 1'b0;
        o_ld_ax    = 1'b0;
        o_fn       = 1'b0;
        o_shift_en = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    w_next = START;
                end else if (i_clear_a_load_b) begin
                    o_clr_ax = 1'b1;
                    o_ld_b   = 1'b1;
                end
            end
            START: begin
                o_busy   = 1'b1;
                o_clr_ax = 1'b1;
                w_next   = ADD;
            end
            ADD: begin
                // Fn only matters when M loads the adder result, but is driven regardless.
                o_busy  = 1'b1;
                o_ld_ax = i_m;
                o_fn    = w_last;
                w_next  = SHIFT;
            end
            SHIFT: begin
                o_busy     = 1'b1;
                o_shift_en = 1'b1;
                w_next     = w_last ? HALT : ADD;
            end
            HALT: begin
                o_done = 1'b1;
                if (!i_run) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control with a small behavioural model of the
// A/X/B datapath so the multiplier bit M and final product come from real operands.
module tb_multiplier_control;

    logic clk = 1'b0;
    logic rstN;
    logic run;
    logic clrLoad;
    logic m;
    logic clrAx, ldB, ldAx, fn, shiftEn, busy, done;

    logic [7:0] switches;
    logic [7:0] modelS;
    logic [7:0] regA;
    logic [7:0] regB;
    logic       regX;
    logic [8:0] sum;
    logic [6:0] outs;

    int nChecks = 0;
    int nFails  = 0;

    int edges, cntClr, cntLdB, cntLdAx, cntFn, cntShift, cntBoth;
    logic lastFn;
    int bad;

    always #5 clk = ~clk;

    multiplier_control #(.N(8)) dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_run            (run),
        .i_clear_a_load_b (clrLoad),
        .i_m              (m),
        .o_clr_ax         (clrAx),
        .o_ld_b           (ldB),
        .o_ld_ax          (ldAx),
        .o_fn             (fn),
        .o_shift_en       (shiftEn),
        .o_busy           (busy),
        .o_done           (done)
    );

    assign m    = regB[0];
    assign outs = {clrAx, ldB, ldAx, fn, shiftEn, busy, done};
    assign sum  = fn ? ({regX, regA} - {modelS[7], modelS})
                     : ({regX, regA} + {modelS[7], modelS});

    // Datapath model: X:A is a 9-bit accumulator, X:A:B shifts right arithmetically.
    always @(posedge clk) begin
        if (clrAx) begin
            {regX, regA} <= 9'd0;
        end else if (ldAx) begin
            {regX, regA} <= sum;
        end else if (shiftEn) begin
            {regX, regA} <= {regX, regX, regA[7:1]};
        end
        if (ldB) begin
            regB <= switches;
        end else if (shiftEn) begin
            regB <= {regA[0], regB[7:1]};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Starts one operation and tallies every output pulse until Done rises.
    task automatic applyStimulus(input logic withClr, input int dropAt);
        edges = 0; cntClr = 0; cntLdB = 0; cntLdAx = 0; cntFn = 0;
        cntShift = 0; cntBoth = 0; lastFn = 1'b0;
        @(negedge clk);
        run     = 1'b1;
        clrLoad = withClr;
        #1;
        cntLdB += int'(ldB);
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            cntClr   += int'(clrAx);
            cntLdB   += int'(ldB);
            cntLdAx  += int'(ldAx);
            cntFn    += int'(ldAx & fn);
            cntShift += int'(shiftEn);
            cntBoth  += int'(ldAx & shiftEn);
            if (ldAx) lastFn = fn;
            if (edges == dropAt) run = 1'b0;
            if (done) break;
        end
    endtask

    initial begin
        rstN = 1'b0; run = 1'b0; clrLoad = 1'b0; switches = 8'h00; modelS = 8'h07;
        regA = 8'h00; regB = 8'h00; regX = 1'b0;
        #3;
        checkOutput("reset_outputs", 32'(outs), 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("first_idle_outputs", 32'(outs), 32'h0);

        // Single-cycle clear/load in IDLE
        @(negedge clk);
        switches = 8'h03; clrLoad = 1'b1;
        #1;
        checkOutput("idle_clr_ldb", 32'({clrAx, ldB, busy}), 32'b110);
        @(negedge clk);
        clrLoad = 1'b0;
        #1;
        checkOutput("idle_after_clr", 32'(outs), 32'h0);
        checkOutput("model_b_loaded", 32'(regB), 32'h03);

        // 3 * 7 = 21 with Run held high
        applyStimulus(1'b0, 0);
        checkOutput("op1_latency", 32'(edges), 32'd18);
        checkOutput("op1_product", 32'({regX, regA, regB}), 32'h00015);
        checkOutput("op1_ldax", 32'(cntLdAx), 32'd2);
        checkOutput("op1_fn", 32'(cntFn), 32'd0);
        checkOutput("op1_shift", 32'(cntShift), 32'd8);
        checkOutput("op1_clr", 32'(cntClr), 32'd1);
        checkOutput("op1_mutex", 32'(cntBoth), 32'd0);

        // Holding Run in HALT never restarts
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!done || busy || clrAx) bad++;
        end
        checkOutput("halt_hold", 32'(bad), 32'd0);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("halt_to_idle", 32'(outs), 32'h0);

        // -1 * 7 = -7, Run dropped early to show it has no effect
        @(negedge clk);
        switches = 8'hFF; clrLoad = 1'b1;
        @(negedge clk);
        clrLoad = 1'b0;
        applyStimulus(1'b0, 4);
        checkOutput("op2_latency", 32'(edges), 32'd18);
        checkOutput("op2_product", 32'({regA, regB}), 32'hFFF9);
        checkOutput("op2_ldax", 32'(cntLdAx), 32'd8);
        checkOutput("op2_fn", 32'(cntFn), 32'd1);
        checkOutput("op2_last_fn", 32'(lastFn), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("op2_back_idle", 32'(outs), 32'h0);

        // Run and ClearA_LoadB together: no load, so B keeps 0xF9 (-7); -7 * 7 = -49
        switches = 8'h55;
        applyStimulus(1'b1, 0);
        checkOutput("op3_latency", 32'(edges), 32'd18);
        checkOutput("op3_ldb", 32'(cntLdB), 32'd0);
        checkOutput("op3_clr", 32'(cntClr), 32'd1);
        checkOutput("op3_product", 32'({regA, regB}), 32'hFFCF);
        @(negedge clk);
        run = 1'b0; clrLoad = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("op3_back_idle", 32'(outs), 32'h0);

        // Asynchronous abort in ADD with cnt=3
        @(negedge clk);
        run = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        checkOutput("abort_pre_busy", 32'({busy, shiftEn}), 32'b10);
        rstN = 1'b0;
        #1;
        checkOutput("abort_outputs", 32'(outs), 32'h0);
        run = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("abort_idle", 32'(outs), 32'h0);
        applyStimulus(1'b0, 0);
        checkOutput("op4_latency", 32'(edges), 32'd18);
        checkOutput("op4_shift", 32'(cntShift), 32'd8);
        checkOutput("op4_mutex", 32'(cntBoth), 32'd0);
        @(negedge clk);
        run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multiplier_control.md
Name: multiplier_control

Overview:
- Sequencing FSM for the 8-bit shift-add signed multiplier datapath.
- Drives the A/B shift-register unit and the 9-bit adder/subtractor, which has sign-extend register X.
- Runs an N-iteration loop: conditional add (subtract on the final iteration), then arithmetic right shift of X:A:B.
- Also handles operand load (B) and accumulator clear (A, X) while idle.

Parameters:
- N, 8: operand width, which is also the iteration count. Counter width is $clog2(N).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset. 0 forces IDLE immediately, independent of Clk.
- Run  input  1  level start request. Synchronised outside this block.
- ClearA_LoadB  input  1  level request: clear A/X and load switches into B. Honoured in IDLE only.
- M  input  1  current multiplier bit (B[0]) from the register unit.
- Clr_AX  output  1  synchronous clear of A and X on the next edge.
- Ld_B  output  1  load switch data into B.
- Ld_AX  output  1  load adder result into A and X.
- Fn  output  1  adder function: 0 = A+S, 1 = A−S.
- Shift_En  output  1  arithmetic right shift X→A→B by one bit.
- Busy  output  1  high in START, ADD, SHIFT.
- Done  output  1  high in HALT.

Behaviour:
- States: IDLE, START, ADD, SHIFT, HALT.
- Iteration counter cnt, width $clog2(N).
- Reset (Reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - Every output is 0 while Reset is low and in the first IDLE cycle after release.
  - Reset asserted mid-operation aborts immediately. Datapath contents are don't-care afterwards.
- IDLE:
  - Run=1 → START.
  - Else ClearA_LoadB=1 → Clr_AX=1 and Ld_B=1 combinationally this cycle; stay in IDLE.
  - Run=1 and ClearA_LoadB=1 together: Run wins. Ld_B=0, go to START.
- START:
  - Clr_AX=1 for exactly one cycle, cnt←0, → ADD.
- ADD (Mealy on M):
  - Ld_AX=M.
  - Fn=1 when cnt==N−1, else 0.
  - Fn is driven even when M=0; it is then don't-care.
  - → SHIFT.
- SHIFT:
  - Shift_En=1.
  - If cnt==N−1 → HALT, cnt held.
  - Else cnt←cnt+1 → ADD.
- HALT:
  - Done=1.
  - Stay while Run=1. Run=0 → IDLE.
  - ClearA_LoadB is ignored in HALT.
- Latency:
  - Run sampled high in IDLE → Done high exactly 2N+2 edges later (18 for N=8): 1 START + N ADD + N SHIFT + entry to HALT.
  - Product is valid in X:A:B while Done=1.
- Pulse counts per operation, exactly:
  - 1 Clr_AX.
  - N Shift_En.
  - popcount(multiplier bits as seen each ADD) Ld_AX.
  - At most one Ld_AX with Fn=1.
- Mutual exclusion: Ld_AX and Shift_En are never high in the same cycle.
- Inputs outside IDLE:
  - Run dropping mid-operation has no effect; the operation completes.
  - In HALT, Run=0 causes the return to IDLE.
  - ClearA_LoadB outside IDLE has no effect.
- Back-to-back operations require Run to go low (passing HALT→IDLE) and then high again. Holding Run high never restarts.
- cnt never wraps; its maximum is N−1.

Test Plan:
- Reset=0 asserted asynchronously mid-ADD (cnt=3) → state=IDLE immediately, all outputs 0, Busy=0, without a clock edge.
- IDLE, ClearA_LoadB=1 for 1 cycle, Run=0 → exactly one cycle of Clr_AX=1 and Ld_B=1; state stays IDLE.
- Datapath model, B=8'h03, S=8'h07, Run held high:
  - Done rises at edge 18.
  - X:A:B = 17'h00015 (21).
  - 2 Ld_AX pulses, both Fn=0.
  - 8 Shift_En pulses.
- B=8'hFF (−1), S=8'h07:
  - 8 Ld_AX pulses, the last with Fn=1.
  - A:B = 16'hFFF9 (−7).
- Run=1 and ClearA_LoadB=1 asserted together in IDLE → Ld_B stays 0, START entered, one Clr_AX.
- Run held high through HALT for 10 cycles → Done stays 1, no restart. Run low → IDLE. Run high → new 18-edge run.
